// File: rtl/cumsum_acc.sv
// cumsum_acc: cumulative-sum accumulator with undo history.
//
// Commands arrive over a valid/ready handshake. The operation is latched on
// the handshake edge and executed on the following edge. The block therefore
// accepts at most one command every two cycles.
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_ni       synchronous active-low reset
//   cmd_valid_i  command present
//   cmd_ready_o  command can be accepted (IDLE and not in reset)
//   cmd_op_i     00 add, 01 undo, 10 clear, 11 nop
//   data_i       addend, zero-extended, used only by add
//   sum_o        registered running sum
//   sum_valid_o  one-cycle pulse when sum_o was updated
//   count_o      number of valid history entries
//   ovf_o        sticky overflow flag, cleared only by clear or reset
//   err_o        one-cycle pulse on undo with empty history
//
// Build option
//   CUMSUM_SATURATE_EN  When defined, an overflowing add saturates.
//                       History then records the amount actually applied,
//                       as a WIDTH-bit entry.
//                       When undefined, an overflowing add wraps and history
//                       records data_i as an IN_W-bit entry.
module cumsum_acc #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IN_W  = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [1:0]                 cmd_op_i,
  input  logic [IN_W-1:0]            data_i,
  output logic [WIDTH-1:0]           sum_o,
  output logic                       sum_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       ovf_o,
  output logic                       err_o
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned PW = $clog2(DEPTH);
`ifdef CUMSUM_SATURATE_EN
  localparam int unsigned HW = WIDTH;
`else
  localparam int unsigned HW = IN_W;
`endif

  typedef enum logic {IDLE, EXEC} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_UNDO = 2'b01,
                            OP_CLEAR = 2'b10, OP_NOP = 2'b11} op_t;

  state_t              state_q, state_d;
  op_t                 op_q;
  logic [IN_W-1:0]     data_q;
  logic [PW-1:0]       wp_q;          // next free slot; newest entry is wp_q-1
  logic [HW-1:0]       hist [DEPTH];

  logic                hs;
  logic [WIDTH:0]      data_ext;
  logic [WIDTH:0]      full;
  logic                add_ovf;
  logic [WIDTH-1:0]    add_sum;
  logic [HW-1:0]       push_val;
  logic [PW-1:0]       top_idx;
  logic [WIDTH-1:0]    top_ext;
  logic [WIDTH-1:0]    undo_sum;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and ready
  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = rst_ni;
        if (cmd_valid_i) state_d = EXEC;
      end
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign hs = cmd_valid_i & cmd_ready_o;

  // Command capture on the handshake edge
  always_ff @(posedge clk_i) begin
    if (hs) begin
      op_q   <= op_t'(cmd_op_i);
      data_q <= data_i;
    end
  end

  // Arithmetic for the pending command
  always_comb begin
    data_ext             = '0;
    data_ext[IN_W-1:0]   = data_q;
    full                 = {1'b0, sum_o} + data_ext;
    add_ovf              = full[WIDTH];
`ifdef CUMSUM_SATURATE_EN
    add_sum              = add_ovf ? '1 : full[WIDTH-1:0];
    // Equals data_q without overflow, and the headroom used when saturating.
    push_val             = add_sum - sum_o;
`else
    add_sum              = full[WIDTH-1:0];
    push_val             = data_q;
`endif
    top_idx              = wp_q - 1'b1;
    top_ext              = '0;
    top_ext[HW-1:0]      = hist[top_idx];
    undo_sum             = sum_o - top_ext;
  end

  // Accumulator, history and result pulses.
  // The history is circular. A push when full overwrites the oldest slot,
  // and count_o saturates at DEPTH. Clear only zeroes the count.
  always_ff @(posedge clk_i) begin
    sum_valid_o <= 1'b0;
    err_o       <= 1'b0;
    if (!rst_ni) begin
      sum_o   <= '0;
      count_o <= '0;
      ovf_o   <= 1'b0;
      wp_q    <= '0;
    end else if (state_q == EXEC) begin
      case (op_q)
        OP_ADD: begin
          sum_o       <= add_sum;
          ovf_o       <= ovf_o | add_ovf;
          hist[wp_q]  <= push_val;
          wp_q        <= wp_q + 1'b1;
          if (count_o != CW'(DEPTH)) count_o <= count_o + 1'b1;
          sum_valid_o <= 1'b1;
        end
        OP_UNDO: begin
          if (count_o == '0) begin
            err_o <= 1'b1;
          end else begin
            sum_o       <= undo_sum;
            wp_q        <= top_idx;
            count_o     <= count_o - 1'b1;
            sum_valid_o <= 1'b1;
          end
        end
        OP_CLEAR: begin
          sum_o       <= '0;
          count_o     <= '0;
          ovf_o       <= 1'b0;
          sum_valid_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cumsum_acc.sv
module tb_cumsum_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op = 2'b11;
  logic [7:0]  data = 8'd0;
  logic [15:0] sum_o;
  logic        sum_valid_o;
  logic [3:0]  count_o;
  logic        ovf_o;
  logic        err_o;

  int passed = 0;
  int total  = 0;

  cumsum_acc #(.WIDTH(16), .IN_W(8), .DEPTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op), .data_i(data), .sum_o(sum_o), .sum_valid_o(sum_valid_o),
    .count_o(count_o), .ovf_o(ovf_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: a sum, a list of applied amounts, a sticky flag,
  // and one pending command executing on the edge after acceptance.
  bit  m_on = 0;
  bit  m_busy = 0;
  int  m_sum = 0;
  bit  m_ovf = 0;
  bit  m_sv = 0;
  bit  m_err = 0;
  int  m_hist[$];
  int  p_op, p_data;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_on = 1; m_busy = 0; m_sum = 0; m_ovf = 0; m_sv = 0; m_err = 0;
      m_hist.delete();
    end else begin
      m_sv = 0; m_err = 0;
      if (m_busy) begin
        m_busy = 0;
        case (p_op)
          0: begin
            int nw, applied;
            nw = m_sum + p_data;
            applied = p_data;
            if (nw > 65535) begin
              m_ovf = 1;
`ifdef CUMSUM_SATURATE_EN
              applied = 65535 - m_sum;
              nw = 65535;
`else
              nw = nw - 65536;
`endif
            end
            m_sum = nw;
            m_hist.push_back(applied);
            if (m_hist.size() > 8) void'(m_hist.pop_front());
            m_sv = 1;
          end
          1: begin
            if (m_hist.size() == 0) m_err = 1;
            else begin
              m_sum = (m_sum - m_hist.pop_back() + 65536) % 65536;
              m_sv = 1;
            end
          end
          2: begin
            m_sum = 0; m_ovf = 0; m_hist.delete(); m_sv = 1;
          end
          default: ;
        endcase
      end else if (cmd_valid) begin
        m_busy = 1; p_op = cmd_op; p_data = data;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_on) begin
      chk("cyc_sum",   sum_o,       m_sum);
      chk("cyc_count", count_o,     m_hist.size());
      chk("cyc_ovf",   ovf_o,       m_ovf);
      chk("cyc_sv",    sum_valid_o, m_sv);
      chk("cyc_err",   err_o,       m_err);
      chk("cyc_ready", cmd_ready_o, (rst_n && !m_busy) ? 1 : 0);
    end
  end

  // Issue one command and check its result one cycle after execution.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, input string nm,
                        input int esum, input bit esv, input bit eerr);
    bit hs = 0;
    @(negedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; data = d;
    for (int i = 0; i < 8 && !hs; i++) begin
      if (cmd_ready_o) hs = 1;
      else begin @(negedge clk); #1; end
    end
    chk({nm, "_handshake"}, hs, 1);
    if (!hs) begin cmd_valid = 1'b0; return; end
    @(negedge clk); #1;
    chk({nm, "_ready_low"}, cmd_ready_o, 0);
    cmd_valid = 1'b0; cmd_op = 2'b11; data = 8'($urandom);
    @(negedge clk); #1;
    chk({nm, "_sum"}, sum_o, esum);
    chk({nm, "_sv"},  sum_valid_o, esv);
    chk({nm, "_err"}, err_o, eerr);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", cmd_ready_o, 0);
    chk("rst_sum", sum_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_pulses", {sum_valid_o, err_o}, 0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rel_ready", cmd_ready_o, 1);

    // Adds then undos past empty
    do_cmd(2'b00, 8'd10, "add10", 10, 1, 0);
    do_cmd(2'b00, 8'd20, "add20", 30, 1, 0);
    do_cmd(2'b00, 8'd30, "add30", 60, 1, 0);
    chk("count3", count_o, 3);
    do_cmd(2'b01, 8'd0, "undo1", 30, 1, 0);
    do_cmd(2'b01, 8'd0, "undo2", 10, 1, 0);
    do_cmd(2'b01, 8'd0, "undo3", 0, 1, 0);
    chk("count0", count_o, 0);
    do_cmd(2'b01, 8'd0, "undo_empty", 0, 0, 1);

    // Build 65530, then overflow and undo
    for (int i = 1; i <= 256; i++) do_cmd(2'b00, 8'd255, "fill", i * 255, 1, 0);
    do_cmd(2'b00, 8'd250, "fill_last", 65530, 1, 0);
    chk("fill_ovf", ovf_o, 0);
`ifdef CUMSUM_SATURATE_EN
    do_cmd(2'b00, 8'd10, "ovf_add", 65535, 1, 0);
`else
    do_cmd(2'b00, 8'd10, "ovf_add", 4, 1, 0);
`endif
    chk("ovf_set", ovf_o, 1);
    chk("ovf_count", count_o, 8);
    do_cmd(2'b01, 8'd0, "ovf_undo", 65530, 1, 0);
    chk("ovf_sticky", ovf_o, 1);

    // Clear, and clear from zero
    do_cmd(2'b10, 8'd0, "clear", 0, 1, 0);
    chk("clear_count", count_o, 0);
    chk("clear_ovf", ovf_o, 0);
    do_cmd(2'b10, 8'd0, "clear0", 0, 1, 0);

    // History depth: nine adds, eight undos, then empty
    for (int i = 1; i <= 9; i++) do_cmd(2'b00, 8'(i), "dep_add", i * (i + 1) / 2, 1, 0);
    chk("dep_sum45", sum_o, 45);
    chk("dep_count8", count_o, 8);
    for (int i = 9; i >= 2; i--) do_cmd(2'b01, 8'd0, "dep_undo", (i - 1) * i / 2, 1, 0);
    chk("dep_count0", count_o, 0);
    do_cmd(2'b01, 8'd0, "dep_undo_empty", 1, 0, 1);

    // Nop and add zero
    do_cmd(2'b11, 8'd77, "nop", 1, 0, 0);
    do_cmd(2'b00, 8'd0, "add0", 1, 1, 0);
    chk("add0_count", count_o, 1);

    // Reset while executing an add of 5
    @(negedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'b00; data = 8'd5;
    chk("rx_ready", cmd_ready_o, 1);
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    chk("rx_ready_rst", cmd_ready_o, 0);
    @(negedge clk); #1;
    chk("rx_sum", sum_o, 0);
    chk("rx_sv", sum_valid_o, 0);
    chk("rx_count", count_o, 0);
    chk("rx_ready_in_rst", cmd_ready_o, 0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rx_ready_after", cmd_ready_o, 1);
    chk("rx_sv_after", sum_valid_o, 0);
    do_cmd(2'b00, 8'd7, "post_rst_add", 7, 1, 0);

    repeat (3) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
